// File: rtl/program_loader.sv
// Program loader: lets a host write program words into RAM over the W-bus while
// holding the CPU controller frozen, then restarts the controller at address 0.
module program_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              cpu_mar_load,
  input  logic              cpu_ram_enable,
  output logic              mar_load,
  output logic              ram_enable,
  output logic              ram_write,
  output logic              bus_drive,
  output logic [DATA_W-1:0] bus_data,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic [ADDR_W-1:0] load_addr,
  output logic              full
);

  typedef enum logic [2:0] {
    StRun,
    StLdWait,
    StLdAddr,
    StLdData,
    StLdFull
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              full_q, full_d;
  logic              restart_q, restart_d;

  logic              accept;
  logic              last_addr;

  // wr_ready is only ever high in StLdWait, so the handshake reduces to this.
  assign accept    = (state_q == StLdWait) && wr_valid;
  assign last_addr = &addr_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    full_d    = full_q;
    restart_d = 1'b0;

    case (state_q)
      StRun: begin
        if (load_mode) begin
          state_d = StLdWait;
          addr_d  = '0;
          full_d  = 1'b0;
        end
      end
      StLdWait: begin
        // A presented word wins over a concurrent exit request.
        if (accept) begin
          state_d = StLdAddr;
          word_d  = wr_data;
        end else if (!load_mode) begin
          state_d   = StRun;
          restart_d = 1'b1;
        end
      end
      StLdAddr: begin
        state_d = StLdData;
      end
      StLdData: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_addr) begin
          state_d = StLdFull;
          full_d  = 1'b1;
        end else begin
          state_d = StLdWait;
        end
      end
      StLdFull: begin
        if (!load_mode) begin
          state_d   = StRun;
          restart_d = 1'b1;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      addr_q    <= '0;
      word_q    <= '0;
      full_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      full_q    <= full_d;
      restart_q <= restart_d;
    end
  end

  // Output decode from registered state; only the RUN pass-through is combinational.
  always_comb begin
    wr_ready   = 1'b0;
    mar_load   = 1'b0;
    ram_enable = 1'b0;
    ram_write  = 1'b0;
    bus_drive  = 1'b0;
    bus_data   = '0;
    cpu_hold   = 1'b1;

    case (state_q)
      StRun: begin
        cpu_hold   = 1'b0;
        mar_load   = cpu_mar_load;
        ram_enable = cpu_ram_enable;
      end
      StLdWait: begin
        wr_ready = 1'b1;
      end
      StLdAddr: begin
        bus_drive = 1'b1;
        bus_data  = DATA_W'(addr_q);
        mar_load  = 1'b1;
      end
      StLdData: begin
        bus_drive = 1'b1;
        bus_data  = word_q;
        ram_write = 1'b1;
      end
      StLdFull: begin
        // Held with no handshake until load_mode drops.
      end
      default: begin
        cpu_hold = 1'b1;
      end
    endcase
  end

  assign cpu_restart = restart_q;
  assign load_addr   = addr_q;
  assign full        = full_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a negedge monitor pushes an expected
// write on every handshake and pops it when the loader performs the RAM write.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_mode = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       cpu_mar_load = 1'b0;
  logic       cpu_ram_enable = 1'b0;
  logic       mar_load, ram_enable, ram_write, bus_drive;
  logic [7:0] bus_data;
  logic       cpu_hold, cpu_restart;
  logic [3:0] load_addr;
  logic       full;

  program_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_mode      (load_mode),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .cpu_mar_load   (cpu_mar_load),
    .cpu_ram_enable (cpu_ram_enable),
    .mar_load       (mar_load),
    .ram_enable     (ram_enable),
    .ram_write      (ram_write),
    .bus_drive      (bus_drive),
    .bus_data       (bus_data),
    .cpu_hold       (cpu_hold),
    .cpu_restart    (cpu_restart),
    .load_addr      (load_addr),
    .full           (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_addr = '0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait at falling edges for wr_ready, bounded.
  task automatic wait_ready(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (!wr_ready && n < max_cyc) begin
      n++;
      @(negedge clk);
    end
    if (!wr_ready) check_eq("ready_timeout", 0, 1);
  endtask

  // Monitor: scoreboard push on handshake, pop on RAM write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check_eq("write_mar_excl", {31'b0, mar_load & ram_write}, 0);
      if (!cpu_hold) check_eq("run_bus_idle", {31'b0, bus_drive}, 0);
      if (cpu_hold) check_eq("hold_ram_en", {31'b0, ram_enable}, 0);
      if (cpu_hold && mar_load) begin
        if (sb.size() == 0) begin
          check_eq("unexp_mar", 1, 0);
        end else begin
          check_eq("addr_bus", {24'b0, bus_data}, {28'b0, sb[0].addr});
          check_eq("addr_drive", {31'b0, bus_drive}, 1);
          check_eq("addr_lat", cyc, sb[0].acc);
        end
      end
      if (ram_write) begin
        if (sb.size() == 0) begin
          check_eq("unexp_write", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("write_data", {24'b0, bus_data}, {24'b0, e.data});
          check_eq("write_addr", {28'b0, load_addr}, {28'b0, e.addr});
          check_eq("write_lat", cyc, e.acc + 1);
        end
      end
      if (reset) begin
        sb.delete();
      end else if (wr_valid && wr_ready) begin
        e.addr = model_addr;
        e.data = wr_data;
        e.acc  = cyc + 1;
        sb.push_back(e);
        model_addr = model_addr + 4'd1;
      end
    end
  end

  initial begin
    int acc, prev_acc, n;

    // Reset state
    step();
    step();
    check_eq("rst_hold", {31'b0, cpu_hold}, 0);
    check_eq("rst_ready", {31'b0, wr_ready}, 0);
    check_eq("rst_full", {31'b0, full}, 0);
    check_eq("rst_addr", {28'b0, load_addr}, 0);
    check_eq("rst_restart", {31'b0, cpu_restart}, 0);
    reset = 1'b0;
    step();

    // Pass-through in RUN
    cpu_mar_load = 1'b1;
    cpu_ram_enable = 1'b0;
    #1;
    check_eq("pt_mar", {31'b0, mar_load}, 1);
    check_eq("pt_ram", {31'b0, ram_enable}, 0);
    check_eq("pt_hold", {31'b0, cpu_hold}, 0);
    cpu_mar_load = 1'b0;
    cpu_ram_enable = 1'b1;
    #1;
    check_eq("pt_mar2", {31'b0, mar_load}, 0);
    check_eq("pt_ram2", {31'b0, ram_enable}, 1);
    step();

    // Single load of 0x1E; controller requests must be ignored
    model_addr = '0;
    load_mode = 1'b1;
    step();
    check_eq("ld_hold", {31'b0, cpu_hold}, 1);
    check_eq("ld_ready", {31'b0, wr_ready}, 1);
    check_eq("ld_addr0", {28'b0, load_addr}, 0);
    cpu_mar_load = 1'b1;
    wr_data = 8'h1E;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    wait_ready(10);
    check_eq("ld_addr1", {28'b0, load_addr}, 1);
    check_eq("ld_sb_empty", sb.size(), 0);
    step();
    cpu_mar_load = 1'b0;

    // Exit from LD_WAIT
    load_mode = 1'b0;
    step();
    check_eq("exit_restart", {31'b0, cpu_restart}, 1);
    check_eq("exit_hold", {31'b0, cpu_hold}, 0);
    step();
    check_eq("exit_restart_end", {31'b0, cpu_restart}, 0);
    cpu_ram_enable = 1'b0;

    // Back-to-back: 16 words with wr_valid held high
    model_addr = '0;
    load_mode = 1'b1;
    step();
    wr_valid = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i);
      wait_ready(10);
      acc = cyc + 1;
      if (i > 0) check_eq("b2b_spacing", acc - prev_acc, 3);
      prev_acc = acc;
      step();
    end
    wr_data = 8'hAA;
    repeat (6) step();
    check_eq("b2b_full", {31'b0, full}, 1);
    check_eq("b2b_ready", {31'b0, wr_ready}, 0);
    check_eq("b2b_addr", {28'b0, load_addr}, 0);
    check_eq("b2b_sb_empty", sb.size(), 0);
    wr_valid = 1'b0;
    load_mode = 1'b0;
    step();
    check_eq("full_exit_restart", {31'b0, cpu_restart}, 1);
    step();

    // Re-entry clears full
    model_addr = '0;
    load_mode = 1'b1;
    step();
    check_eq("reenter_full", {31'b0, full}, 0);
    check_eq("reenter_addr", {28'b0, load_addr}, 0);

    // Simultaneous accept and exit request
    wr_data = 8'h3C;
    wr_valid = 1'b1;
    load_mode = 1'b0;
    @(negedge clk);
    acc = cyc + 1;
    step();
    wr_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!cpu_restart && n < 10) begin
      n++;
      @(negedge clk);
    end
    check_eq("sim_restart", {31'b0, cpu_restart}, 1);
    check_eq("sim_restart_cyc", cyc, acc + 3);
    check_eq("sim_addr", {28'b0, load_addr}, 1);
    check_eq("sim_hold", {31'b0, cpu_hold}, 0);
    step();

    // Reset during LD_ADDR abandons the write; load_mode held through reset
    model_addr = '0;
    load_mode = 1'b1;
    step();
    wr_data = 8'h55;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    reset = 1'b1;
    step();
    check_eq("rmid_hold", {31'b0, cpu_hold}, 0);
    check_eq("rmid_addr", {28'b0, load_addr}, 0);
    check_eq("rmid_full", {31'b0, full}, 0);
    check_eq("rmid_write", {31'b0, ram_write}, 0);
    step();
    reset = 1'b0;
    check_eq("rrel_run", {31'b0, cpu_hold}, 0);
    step();
    check_eq("rrel_wait", {31'b0, cpu_hold}, 1);
    check_eq("rrel_ready", {31'b0, wr_ready}, 1);
    repeat (4) step();
    load_mode = 1'b0;
    step();
    check_eq("rrel_restart", {31'b0, cpu_restart}, 1);
    repeat (2) step();

    check_eq("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
